// File: rtl/sweep_scheduler_if.sv
// rtl/sweep_scheduler_if.sv - control/status bundle between sweep host and sweep_scheduler
interface sweep_scheduler_if;
    logic       start;
    logic       stop;
    logic [3:0] port_mask;
    logic [7:0] repeat_count;
    logic       acq_ready;
    logic [1:0] switch_state;
    logic       state_change;
    logic       vna_trigger;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] pass_count;

    modport master (
        output start, stop, port_mask, repeat_count, acq_ready,
        input  switch_state, state_change, vna_trigger, busy, done, timeout_err, pass_count
    );

    modport slave (
        input  start, stop, port_mask, repeat_count, acq_ready,
        output switch_state, state_change, vna_trigger, busy, done, timeout_err, pass_count
    );
endinterface

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - steps an RF switch through masked states and triggers a VNA sweep per state
module sweep_scheduler #(
    parameter logic [23:0] SETTLE_CYCLES  = 24'd500000,
    parameter logic [15:0] TRIG_CYCLES    = 16'd50,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd250000000
) (
    input  logic               clk_50,
    input  logic               rst,
    sweep_scheduler_if.slave   sif
);

    typedef enum logic [2:0] {IDLE, SWITCH, SETTLE, TRIG, WAIT_ACQ, NEXT} state_t;

    localparam logic [27:0] SETTLE_LAST  = 28'(SETTLE_CYCLES) - 28'd1;
    localparam logic [27:0] TRIG_LAST    = 28'(TRIG_CYCLES) - 28'd1;
    localparam logic [27:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 28'd1;

    state_t      state, state_nxt;
    logic [27:0] cnt;
    logic [3:0]  mask_q;
    logic [7:0]  repeat_q;
    logic [1:0]  index_q, index_nxt;
    logic [7:0]  pass_q, pass_nxt, pass_inc;
    logic        timeout_q, timeout_nxt;
    logic        done_q, done_nxt;
    logic        load;
    logic [2:0]  higher;
    logic        acq_s1, acq_s2, acq_s3;
    logic        acq_edge;

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // {found, index} of the nearest set bit strictly above cur
    function automatic logic [2:0] next_higher(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign acq_edge = acq_s2 & ~acq_s3;
    assign higher   = next_higher(mask_q, index_q);
    assign pass_inc = pass_q + 8'd1;

    always_comb begin
        state_nxt   = state;
        index_nxt   = index_q;
        pass_nxt    = pass_q;
        timeout_nxt = timeout_q;
        done_nxt    = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (sif.start && (sif.port_mask != 4'd0)) begin
                    state_nxt   = SWITCH;
                    index_nxt   = lowest_bit(sif.port_mask);
                    pass_nxt    = 8'd0;
                    timeout_nxt = 1'b0;
                    load        = 1'b1;
                end
            end
            SWITCH:   state_nxt = SETTLE;
            SETTLE:   if (cnt == SETTLE_LAST) state_nxt = TRIG;
            TRIG:     if (cnt == TRIG_LAST) state_nxt = WAIT_ACQ;
            WAIT_ACQ: begin
                if (acq_edge) begin
                    state_nxt = NEXT;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            NEXT: begin
                if (higher[2]) begin
                    index_nxt = higher[1:0];
                    state_nxt = SWITCH;
                end else begin
                    pass_nxt = pass_inc;
                    if ((repeat_q != 8'd0) && (pass_inc == repeat_q)) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        index_nxt = lowest_bit(mask_q);
                        state_nxt = SWITCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort leaves switch position and pass count frozen where they were
        if ((state != IDLE) && sif.stop) begin
            state_nxt   = IDLE;
            index_nxt   = index_q;
            pass_nxt    = pass_q;
            timeout_nxt = timeout_q;
            done_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 28'd0;
            mask_q    <= 4'd0;
            repeat_q  <= 8'd0;
            index_q   <= 2'd0;
            pass_q    <= 8'd0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            acq_s1    <= 1'b0;
            acq_s2    <= 1'b0;
            acq_s3    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= ((state_nxt != state) || (state == IDLE)) ? 28'd0 : cnt + 28'd1;
            index_q   <= index_nxt;
            pass_q    <= pass_nxt;
            timeout_q <= timeout_nxt;
            done_q    <= done_nxt;
            acq_s1    <= sif.acq_ready;
            acq_s2    <= acq_s1;
            acq_s3    <= acq_s2;
            if (load) begin
                mask_q   <= sif.port_mask;
                repeat_q <= sif.repeat_count;
            end
        end
    end

    assign sif.switch_state = index_q;
    assign sif.state_change = (state == SWITCH);
    assign sif.vna_trigger  = (state == TRIG);
    assign sif.busy         = (state != IDLE);
    assign sif.done         = done_q;
    assign sif.timeout_err  = timeout_q;
    assign sif.pass_count   = pass_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb/tb_sweep_scheduler.sv - self-checking bench for sweep_scheduler
module tb_sweep_scheduler;

    localparam int SETTLE  = 10;
    localparam int TRIG    = 4;
    localparam int TIMEOUT = 100;

    logic clk_50 = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    sweep_scheduler_if sif();

    sweep_scheduler #(
        .SETTLE_CYCLES (24'd10),
        .TRIG_CYCLES   (16'd4),
        .TIMEOUT_CYCLES(28'd100)
    ) dut (
        .clk_50(clk_50),
        .rst   (rst),
        .sif   (sif)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // event log: cycle numbers of state_change / trigger edges, done pulse count
    int   sc_cyc[$];
    int   sc_val[$];
    int   rise_cyc[$];
    int   fall_cyc[$];
    int   done_cnt = 0;
    logic trig_prev = 1'b0;

    always @(negedge clk_50) begin
        if (sif.state_change === 1'b1) begin
            sc_cyc.push_back(cyc);
            sc_val.push_back(int'(sif.switch_state));
        end
        if (sif.vna_trigger === 1'b1 && trig_prev === 1'b0) rise_cyc.push_back(cyc);
        if (sif.vna_trigger === 1'b0 && trig_prev === 1'b1) fall_cyc.push_back(cyc);
        trig_prev <= sif.vna_trigger;
        if (sif.done === 1'b1) done_cnt++;
    end

    // VNA model: answers each trigger with an acq_ready pulse after a delay
    bit resp_en    = 1'b0;
    int resp_fixed = -1;

    initial begin : responder
        logic prev;
        int   d;
        prev = 1'b0;
        forever begin
            @(negedge clk_50);
            if (resp_en && prev && sif.vna_trigger === 1'b0) begin
                d = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 60));
                repeat (d) @(posedge clk_50);
                #1 sif.acq_ready = 1'b1;
                repeat (3) @(posedge clk_50);
                #1 sif.acq_ready = 1'b0;
                prev = 1'b0;
            end else begin
                prev = sif.vna_trigger;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sif.start = 1'b0;
        sif.stop = 1'b0;
        sif.acq_ready = 1'b0;
        repeat (2) @(posedge clk_50);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [7:0] r, input logic with_stop);
        @(posedge clk_50);
        #1;
        sif.port_mask = m;
        sif.repeat_count = r;
        sif.start = 1'b1;
        sif.stop = with_stop;
        @(posedge clk_50);
        #1;
        sif.start = 1'b0;
        sif.stop = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk_50);
        #1 sif.stop = 1'b1;
        @(posedge clk_50);
        #1 sif.stop = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        logic [21:0] got;
        got = {sif.switch_state, sif.state_change, sif.vna_trigger, sif.busy,
               sif.done, sif.timeout_err, sif.pass_count, 7'd0};
        checks++;
        if (got !== 22'd0) begin
            fails++;
            $display("FAIL %s outputs: got %h, required 0 (sw=%0d sc=%b trig=%b busy=%b done=%b to=%b pass=%0d)",
                     tag, got, sif.switch_state, sif.state_change, sif.vna_trigger, sif.busy,
                     sif.done, sif.timeout_err, sif.pass_count);
        end
    endtask

    task automatic run_sweep(input string tag, input logic [3:0] mask, input logic [7:0] rep, input int delay);
        int exp_vals[$];
        int sb, rb, fb, db, n, k;
        for (int p = 0; p < int'(rep); p++)
            for (int b = 0; b < 4; b++)
                if (mask[b]) exp_vals.push_back(b);
        n = exp_vals.size();
        sb = sc_cyc.size(); rb = rise_cyc.size(); fb = fall_cyc.size(); db = done_cnt;
        resp_fixed = delay;
        resp_en = 1'b1;
        pulse_start(mask, rep, 1'b0);
        k = 0;
        do begin @(negedge clk_50); k++; end while (sif.busy !== 1'b0 && k < 5000);
        @(negedge clk_50);
        resp_en = 1'b0;
        checks++;
        if (k >= 5000) begin fails++; $display("FAIL %s sweep_end: still busy after %0d cycles, required idle", tag, k); end
        checks++;
        if (sc_cyc.size() - sb != n || rise_cyc.size() - rb != n || fall_cyc.size() - fb != n) begin
            fails++;
            $display("FAIL %s step_count: state_change=%0d rises=%0d falls=%0d, required %0d each (mask=%b rep=%0d)",
                     tag, sc_cyc.size() - sb, rise_cyc.size() - rb, fall_cyc.size() - fb, n, mask, rep);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (sc_val[sb+i] != exp_vals[i] || rise_cyc[rb+i] != sc_cyc[sb+i] + 1 + SETTLE
                    || fall_cyc[fb+i] != sc_cyc[sb+i] + 1 + SETTLE + TRIG) begin
                    fails++;
                    $display("FAIL %s step%0d: sw=%0d rise=+%0d fall=+%0d, required sw=%0d rise=+%0d fall=+%0d",
                             tag, i, sc_val[sb+i], rise_cyc[rb+i] - sc_cyc[sb+i], fall_cyc[fb+i] - sc_cyc[sb+i],
                             exp_vals[i], 1 + SETTLE, 1 + SETTLE + TRIG);
                end
            end
        end
        checks++;
        if (done_cnt - db != 1) begin fails++; $display("FAIL %s done_count: got %0d, required 1", tag, done_cnt - db); end
        checks++;
        if (sif.pass_count !== rep) begin fails++; $display("FAIL %s pass_count: got %0d, required %0d", tag, sif.pass_count, rep); end
        checks++;
        if (sif.timeout_err !== 1'b0) begin fails++; $display("FAIL %s timeout_err: got %b, required 0", tag, sif.timeout_err); end
        repeat (80) @(negedge clk_50);
    endtask

    task automatic test_directed_sweep();
        do_reset();
        run_sweep("directed", 4'b1011, 8'd2, 5);
    endtask

    task automatic test_random_sweeps();
        logic [3:0] m;
        logic [7:0] r;
        for (int it = 0; it < 5; it++) begin
            m = 4'($urandom_range(1, 15));
            r = 8'($urandom_range(1, 3));
            run_sweep($sformatf("random%0d", it), m, r, -1);
        end
    endtask

    task automatic test_continuous_stop();
        int sb, db, k;
        do_reset();
        sb = sc_cyc.size(); db = done_cnt;
        resp_fixed = -1;
        resp_en = 1'b1;
        pulse_start(4'b0100, 8'd0, 1'b0);
        k = 0;
        do begin @(negedge clk_50); k++; end while (sc_cyc.size() - sb < 8 && k < 3000);
        checks++;
        if (k >= 3000) begin fails++; $display("FAIL cont eighth_switch: %0d switches seen, required 8", sc_cyc.size() - sb); end
        checks++;
        if (sif.busy !== 1'b1) begin fails++; $display("FAIL cont busy_before_stop: got %b, required 1", sif.busy); end
        pulse_stop();
        resp_en = 1'b0;
        @(negedge clk_50);
        checks++;
        if (sif.busy !== 1'b0 || sif.vna_trigger !== 1'b0) begin
            fails++; $display("FAIL cont busy_after_stop: busy=%b trig=%b, required 0 0", sif.busy, sif.vna_trigger);
        end
        repeat (80) @(negedge clk_50);
        checks++;
        if (sif.pass_count !== 8'd7) begin fails++; $display("FAIL cont pass_count: got %0d, required 7", sif.pass_count); end
        checks++;
        if (sif.switch_state !== 2'd2) begin fails++; $display("FAIL cont switch_state: got %0d, required 2", sif.switch_state); end
        checks++;
        if (done_cnt != db) begin fails++; $display("FAIL cont no_done: got %0d pulses, required 0", done_cnt - db); end
        checks++;
        if (sc_cyc.size() - sb != 8) begin fails++; $display("FAIL cont switch_count: got %0d, required 8", sc_cyc.size() - sb); end
        for (int i = sb; i < sc_cyc.size(); i++) begin
            checks++;
            if (sc_val[i] != 2) begin fails++; $display("FAIL cont step_state: got %0d, required 2", sc_val[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] m;
        int fb, db, k, w, t_err;
        do_reset();
        m = 4'($urandom_range(1, 15));
        fb = fall_cyc.size(); db = done_cnt;
        resp_en = 1'b0;
        pulse_start(m, 8'd1, 1'b0);
        k = 0;
        do begin @(negedge clk_50); k++; end while (fall_cyc.size() == fb && k < 100);
        checks++;
        if (fall_cyc.size() == fb) begin
            fails++; $display("FAIL timeout wait_entry: no trigger end within %0d cycles", k);
        end else begin
            w = fall_cyc[fb];
            k = 0;
            while (sif.timeout_err !== 1'b1 && k < 300) begin @(negedge clk_50); k++; end
            t_err = cyc;
            checks++;
            if (t_err - w != TIMEOUT) begin fails++; $display("FAIL timeout latency: got %0d cycles, required %0d", t_err - w, TIMEOUT); end
            checks++;
            if (sif.busy !== 1'b0) begin fails++; $display("FAIL timeout busy: got %b, required 0", sif.busy); end
        end
        @(negedge clk_50);
        checks++;
        if (done_cnt != db) begin fails++; $display("FAIL timeout no_done: got %0d pulses, required 0", done_cnt - db); end
        pulse_start(m, 8'd1, 1'b0);
        @(negedge clk_50);
        checks++;
        if (sif.timeout_err !== 1'b0 || sif.busy !== 1'b1) begin
            fails++; $display("FAIL timeout restart_clear: timeout_err=%b busy=%b, required 0 1", sif.timeout_err, sif.busy);
        end
        pulse_stop();
        repeat (10) @(negedge clk_50);
    endtask

    task automatic test_ignored_inputs();
        int sb, fb, db, k;
        do_reset();
        resp_en = 1'b0;
        pulse_start(4'b0000, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_50);
            checks++;
            if (sif.busy !== 1'b0 || sif.state_change !== 1'b0 || sif.switch_state !== 2'd0) begin
                fails++; $display("FAIL ignore zero_mask: busy=%b sc=%b sw=%0d, required 0 0 0", sif.busy, sif.state_change, sif.switch_state);
            end
        end
        sb = sc_cyc.size(); fb = fall_cyc.size(); db = done_cnt;
        pulse_start(4'b0010, 8'd1, 1'b1);
        #1;
        checks++;
        if (sif.busy !== 1'b1 || sif.switch_state !== 2'd1) begin
            fails++; $display("FAIL ignore start_beats_stop: busy=%b sw=%0d, required 1 1", sif.busy, sif.switch_state);
        end
        // late start, mask/repeat change and an acq pulse during SETTLE must all be ignored
        @(posedge clk_50);
        #1;
        sif.start = 1'b1; sif.port_mask = 4'b1111; sif.repeat_count = 8'd5; sif.acq_ready = 1'b1;
        @(posedge clk_50);
        #1 sif.start = 1'b0;
        repeat (2) @(posedge clk_50);
        #1 sif.acq_ready = 1'b0;
        k = 0;
        do begin @(negedge clk_50); k++; end while (fall_cyc.size() == fb && k < 50);
        repeat (30) @(negedge clk_50);
        checks++;
        if (sif.busy !== 1'b1 || sif.pass_count !== 8'd0 || sc_cyc.size() - sb != 1) begin
            fails++; $display("FAIL ignore stale_edge: busy=%b pass=%0d switches=%0d, required 1 0 1", sif.busy, sif.pass_count, sc_cyc.size() - sb);
        end
        @(posedge clk_50);
        #1 sif.acq_ready = 1'b1;
        repeat (3) @(posedge clk_50);
        #1 sif.acq_ready = 1'b0;
        repeat (10) @(negedge clk_50);
        checks++;
        if (sif.busy !== 1'b0 || sif.pass_count !== 8'd1 || done_cnt - db != 1 || sc_cyc.size() - sb != 1) begin
            fails++; $display("FAIL ignore latched_cfg: busy=%b pass=%0d done=%0d switches=%0d, required 0 1 1 1",
                              sif.busy, sif.pass_count, done_cnt - db, sc_cyc.size() - sb);
        end
    endtask

    task automatic test_reset_in_trig();
        int k;
        do_reset();
        resp_fixed = -1;
        resp_en = 1'b1;
        pulse_start(4'($urandom_range(1, 15)), 8'd2, 1'b0);
        k = 0;
        do begin @(negedge clk_50); k++; end while (sif.vna_trigger !== 1'b1 && k < 60);
        checks++;
        if (sif.vna_trigger !== 1'b1) begin fails++; $display("FAIL rst_trig reach_trig: trigger=%b, required 1", sif.vna_trigger); end
        resp_en = 1'b0;
        #2 rst = 1'b1;
        #1 test_reset("rst_trig");
        @(posedge clk_50);
        #1 rst = 1'b0;
        repeat (80) @(negedge clk_50);
    endtask

    initial begin
        rst = 1'b1;
        sif.start = 1'b0;
        sif.stop = 1'b0;
        sif.port_mask = 4'd0;
        sif.repeat_count = 8'd0;
        sif.acq_ready = 1'b0;
        #3 test_reset("reset");
        test_directed_sweep();
        test_random_sweeps();
        test_continuous_stop();
        test_timeout();
        test_ignored_inputs();
        test_reset_in_trig();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
